regfile_2r1w: RTL and testbench

Parametrised successor to the 16x16 structural register bank. Holds DEPTH registers of WIDTH bits, with one synchronous write port and two combinational read ports, so the ALU gets both operands in one cycle. Adds a selectable write-to-read bypass, an optional hardwired-zero r0, a per-register pending scoreboard for multi-cycle loads, and a processor status register (PSR) with its own write enable. Sits between the decoder/ALU datapath and the writeback bus.

---
 rtl/regfile_2r1w.sv | 83 ++++++++
 tb/tb_regfile_2r1w.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Parametrised register bank: one synchronous write port, two combinational read ports,
// optional write-to-read bypass and hardwired-zero r0, a load scoreboard and a status register.
module regfile_2r1w #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1,
    parameter int PSR_W   = 5,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic             pend_set,
    input  logic [AW-1:0]    pend_addr,
    output logic             pend_a,
    output logic             pend_b,
    input  logic             psr_we,
    input  logic [PSR_W-1:0] psr_in,
    output logic [PSR_W-1:0] psr_out
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             wr_ok;
    logic             set_ok;

    // An address is live if it names a real register and is not the hardwired-zero r0.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_L) && !((ZERO_R0 != 0) && (addr == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
        if (!addr_ok(addr))
            return '0;
        if ((BYPASS != 0) && wr_en && !reset && (wr_addr == addr))
            return wr_data;
        return regs[addr];
    endfunction

    always_comb begin
        wr_ok  = wr_en && addr_ok(wr_addr);
        set_ok = pend_set && addr_ok(pend_addr);
    end

    // NOTE: the register array is reset explicitly because software relies on reading zeros after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pend    <= '0;
            psr_out <= '0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            // A new load issued on the same edge as the previous result's writeback keeps the bit set.
            for (int i = 0; i < DEPTH; i++) begin
                if (set_ok && (pend_addr == AW'(i)))
                    pend[i] <= 1'b1;
                else if (wr_ok && (wr_addr == AW'(i)))
                    pend[i] <= 1'b0;
            end
            if (psr_we)
                psr_out <= psr_in;
        end
    end

    always_comb begin
        rd_a_data = read_word(rd_a_addr);
        rd_b_data = read_word(rd_b_addr);
        pend_a    = addr_ok(rd_a_addr) && pend[rd_a_addr];
        pend_b    = addr_ok(rd_b_addr) && pend[rd_b_addr];
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a default instance (bypass on, r0 writable) and an alternate
// instance (12 registers, hardwired-zero r0, no bypass) compared against an array model.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_a_addr;
    logic [3:0]  rd_b_addr;
    logic        pend_set;
    logic [3:0]  pend_addr;
    logic        psr_we;
    logic [4:0]  psr_in;

    logic [15:0] d0_rd_a, d0_rd_b, d1_rd_a, d1_rd_b;
    logic        d0_pend_a, d0_pend_b, d1_pend_a, d1_pend_b;
    logic [4:0]  d0_psr, d1_psr;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = default instance, index 1 = alternate instance.
    logic [15:0] mem_m  [2][16];
    logic        pend_m [2][16];
    logic [4:0]  psr_m;

    always #5 clk = ~clk;

    regfile_2r1w dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_a_addr(rd_a_addr), .rd_a_data(d0_rd_a), .rd_b_addr(rd_b_addr), .rd_b_data(d0_rd_b),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(d0_pend_a), .pend_b(d0_pend_b),
        .psr_we(psr_we), .psr_in(psr_in), .psr_out(d0_psr)
    );

    regfile_2r1w #(.WIDTH(16), .DEPTH(12), .ZERO_R0(1), .BYPASS(0), .PSR_W(5)) dut_alt (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_a_addr(rd_a_addr), .rd_a_data(d1_rd_a), .rd_b_addr(rd_b_addr), .rd_b_data(d1_rd_b),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(d1_pend_a), .pend_b(d1_pend_b),
        .psr_we(psr_we), .psr_in(psr_in), .psr_out(d1_psr)
    );

    function automatic bit legal(input int k, input logic [3:0] addr);
        int depth = (k == 1) ? 12 : 16;
        return (int'(addr) < depth) && !((k == 1) && (addr == 4'd0));
    endfunction

    function automatic logic [15:0] exp_rd(input int k, input logic [3:0] addr);
        if (!legal(k, addr))
            return 16'h0000;
        if ((k == 0) && wr_en && !reset && (wr_addr == addr))
            return wr_data;
        return mem_m[k][addr];
    endfunction

    function automatic logic exp_pend(input int k, input logic [3:0] addr);
        return legal(k, addr) && pend_m[k][addr];
    endfunction

    task automatic model_step();
        if (reset) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 16; i++) begin
                    mem_m[k][i]  = 16'h0000;
                    pend_m[k][i] = 1'b0;
                end
            psr_m = 5'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en && legal(k, wr_addr)) begin
                    mem_m[k][wr_addr]  = wr_data;
                    pend_m[k][wr_addr] = 1'b0;
                end
                if (pend_set && legal(k, pend_addr))
                    pend_m[k][pend_addr] = 1'b1;
            end
            if (psr_we)
                psr_m = psr_in;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; wr_en = 1'b0; pend_set = 1'b0; psr_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; pend_set = 1'b0; psr_we = 1'b0;
        wr_addr = '0; wr_data = '0; pend_addr = '0; psr_in = '0;
        rd_a_addr = '0; rd_b_addr = '0;
        tick();
        idle();
        for (int a = 0; a < 16; a++) begin
            rd_a_addr = 4'(a);
            rd_b_addr = 4'(15 - a);
            #1;
            checks += 4;
            if (d0_rd_a !== 16'h0000 || d0_rd_b !== 16'h0000) begin
                errors++;
                $display("FAIL reset_data dut addr %0d: got a=%h b=%h expected 0000", a, d0_rd_a, d0_rd_b);
            end
            if (d1_rd_a !== 16'h0000 || d1_rd_b !== 16'h0000) begin
                errors++;
                $display("FAIL reset_data alt addr %0d: got a=%h b=%h expected 0000", a, d1_rd_a, d1_rd_b);
            end
            if ({d0_pend_a, d0_pend_b, d1_pend_a, d1_pend_b} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_pend addr %0d: got %b expected 0000", a,
                         {d0_pend_a, d0_pend_b, d1_pend_a, d1_pend_b});
            end
            if (d0_psr !== 5'd0 || d1_psr !== 5'd0) begin
                errors++;
                $display("FAIL reset_psr: got %b/%b expected 00000", d0_psr, d1_psr);
            end
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 4'd3;  wr_data = 16'hBEEF; tick();
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'h1234; tick();
        idle();
        rd_a_addr = 4'd3; rd_b_addr = 4'd12; #1;
        checks += 3;
        if (d0_rd_a !== 16'hBEEF || d0_rd_b !== 16'h1234) begin
            errors++;
            $display("FAIL write_read dut: got a=%h b=%h expected beef 1234", d0_rd_a, d0_rd_b);
        end
        if (d1_rd_a !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read alt r3: got %h expected beef", d1_rd_a);
        end
        if (d1_rd_b !== 16'h0000) begin
            errors++;
            $display("FAIL out_of_range alt r12: got %h expected 0000", d1_rd_b);
        end
        for (int a = 0; a < 16; a++) begin
            rd_a_addr = 4'(a); rd_b_addr = 4'(a); #1;
            checks++;
            if (d0_rd_a !== exp_rd(0, 4'(a)) || d0_rd_b !== d0_rd_a) begin
                errors++;
                $display("FAIL others_unchanged r%0d: got a=%h b=%h expected %h", a, d0_rd_a, d0_rd_b, exp_rd(0, 4'(a)));
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] old_alt;
        old_alt = mem_m[1][5];
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hA5A5; rd_a_addr = 4'd5; #1;
        checks += 2;
        if (d0_rd_a !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_on: got %h expected a5a5", d0_rd_a);
        end
        if (d1_rd_a !== old_alt) begin
            errors++;
            $display("FAIL bypass_off_same_cycle: got %h expected %h", d1_rd_a, old_alt);
        end
        tick();
        idle(); #1;
        checks++;
        if (d1_rd_a !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_off_next_cycle: got %h expected a5a5", d1_rd_a);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        pend_set = 1'b1; pend_addr = 4'd0; rd_a_addr = 4'd0; #1;
        checks++;
        if (d1_rd_a !== 16'h0000) begin
            errors++;
            $display("FAIL zero_r0_bypass alt: got %h expected 0000", d1_rd_a);
        end
        tick();
        idle(); #1;
        checks += 2;
        if (d1_rd_a !== 16'h0000 || d1_pend_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_r0 alt: got data=%h pend=%b expected 0000 0", d1_rd_a, d1_pend_a);
        end
        if (d0_rd_a !== 16'hFFFF || d0_pend_a !== 1'b1) begin
            errors++;
            $display("FAIL r0_writable dut: got data=%h pend=%b expected ffff 1", d0_rd_a, d0_pend_a);
        end
    endtask

    task automatic test_scoreboard();
        pend_set = 1'b1; pend_addr = 4'd7; tick();
        idle(); rd_a_addr = 4'd7; rd_b_addr = 4'd7; #1;
        checks++;
        if ({d0_pend_a, d0_pend_b, d1_pend_a, d1_pend_b} !== 4'b1111) begin
            errors++;
            $display("FAIL pend_set r7: got %b expected 1111", {d0_pend_a, d0_pend_b, d1_pend_a, d1_pend_b});
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0042; #1;
        checks++;
        if (d0_pend_a !== 1'b1 || d0_rd_a !== 16'h0042) begin
            errors++;
            $display("FAIL pend_not_bypassed: got pend=%b data=%h expected 1 0042", d0_pend_a, d0_rd_a);
        end
        tick();
        idle(); #1;
        checks += 2;
        if (d0_pend_a !== 1'b0 || d1_pend_a !== 1'b0) begin
            errors++;
            $display("FAIL pend_clear r7: got %b/%b expected 0/0", d0_pend_a, d1_pend_a);
        end
        if (d0_rd_a !== 16'h0042 || d1_rd_a !== 16'h0042) begin
            errors++;
            $display("FAIL load_data r7: got %h/%h expected 0042", d0_rd_a, d1_rd_a);
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0099; pend_set = 1'b1; pend_addr = 4'd7; tick();
        idle(); #1;
        checks++;
        if (d0_rd_a !== 16'h0099 || d1_rd_a !== 16'h0099 || d0_pend_a !== 1'b1 || d1_pend_a !== 1'b1) begin
            errors++;
            $display("FAIL set_and_write r7: got %h/%h pend %b/%b expected 0099 pend 1/1",
                     d0_rd_a, d1_rd_a, d0_pend_a, d1_pend_a);
        end
        pend_set = 1'b1; pend_addr = 4'd13; wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'h7777; tick();
        pend_set = 1'b1; pend_addr = 4'd13; wr_en = 1'b0; tick();
        idle(); rd_b_addr = 4'd13; #1;
        checks += 2;
        if (d1_pend_b !== 1'b0 || d1_rd_b !== 16'h0000) begin
            errors++;
            $display("FAIL out_of_range alt r13: got pend=%b data=%h expected 0 0000", d1_pend_b, d1_rd_b);
        end
        if (d0_pend_b !== 1'b1 || d0_rd_b !== 16'h7777) begin
            errors++;
            $display("FAIL in_range dut r13: got pend=%b data=%h expected 1 7777", d0_pend_b, d0_rd_b);
        end
    endtask

    task automatic test_psr_and_reset();
        psr_we = 1'b1; psr_in = 5'b10110; tick();
        idle(); #1;
        checks++;
        if (d0_psr !== 5'b10110 || d1_psr !== 5'b10110) begin
            errors++;
            $display("FAIL psr_write: got %b/%b expected 10110", d0_psr, d1_psr);
        end
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1111; pend_set = 1'b1; pend_addr = 4'd2; tick();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF;
        pend_set = 1'b1; pend_addr = 4'd2; psr_we = 1'b1; psr_in = 5'b11111; tick();
        idle(); rd_a_addr = 4'd2; rd_b_addr = 4'd2; #1;
        checks += 2;
        if (d0_rd_a !== 16'h0000 || d1_rd_b !== 16'h0000 || d0_pend_a !== 1'b0 || d1_pend_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load r2: got %h/%h pend %b/%b expected 0000 pend 0",
                     d0_rd_a, d1_rd_b, d0_pend_a, d1_pend_b);
        end
        if (d0_psr !== 5'd0 || d1_psr !== 5'd0) begin
            errors++;
            $display("FAIL reset_psr_mid: got %b/%b expected 00000", d0_psr, d1_psr);
        end
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222; tick();
        idle(); #1;
        checks++;
        if (d0_rd_a !== 16'h2222 || d0_pend_a !== 1'b0) begin
            errors++;
            $display("FAIL late_load r2: got %h pend=%b expected 2222 0", d0_rd_a, d0_pend_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_addr   = 4'($urandom_range(0, 15));
            wr_data   = 16'($urandom);
            pend_set  = $urandom_range(0, 2) == 0;
            pend_addr = 4'($urandom_range(0, 15));
            psr_we    = $urandom_range(0, 3) == 0;
            psr_in    = 5'($urandom);
            rd_a_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_b_addr = 4'($urandom_range(0, 15));
            #1;
            for (int k = 0; k < 2; k++) begin
                logic [15:0] ga, gb;
                logic        pa, pb;
                logic [4:0]  ps;
                ga = (k == 0) ? d0_rd_a : d1_rd_a;
                gb = (k == 0) ? d0_rd_b : d1_rd_b;
                pa = (k == 0) ? d0_pend_a : d1_pend_a;
                pb = (k == 0) ? d0_pend_b : d1_pend_b;
                ps = (k == 0) ? d0_psr : d1_psr;
                checks++;
                if (ga !== exp_rd(k, rd_a_addr) || gb !== exp_rd(k, rd_b_addr) ||
                    pa !== exp_pend(k, rd_a_addr) || pb !== exp_pend(k, rd_b_addr) || ps !== psr_m) begin
                    errors++;
                    $display("FAIL random inst%0d cycle %0d: got a=%h b=%h pa=%b pb=%b psr=%b expected a=%h b=%h pa=%b pb=%b psr=%b",
                             k, n, ga, gb, pa, pb, ps, exp_rd(k, rd_a_addr), exp_rd(k, rd_b_addr),
                             exp_pend(k, rd_a_addr), exp_pend(k, rd_b_addr), psr_m);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_psr_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
